// File: rtl/soc_mem_mc_pkg.sv
// rtl/soc_mem_mc_pkg.sv - shared types and helpers for the multi-channel SoC word memory
//
// Purpose: default geometry of the memory, the per-grant operation type and
//          the round-robin next-pointer function used by soc_mem_mc.
// Ports:   none (package).
package soc_mem_mc_pkg;

    localparam int DEF_WORD_WIDTH  = 4;
    localparam int DEF_INDEX_WIDTH = 4;
    localparam int DEF_NUM_CH      = 2;

    typedef enum logic [0:0] {OP_RD, OP_WR} mem_op_e;

    // Pointer moves to the channel just after the one served, wrapping at num_ch.
    function automatic int rr_next(input int k, input int num_ch);
        return (k + 1 >= num_ch) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/soc_rr_arb.sv
// rtl/soc_rr_arb.sv - combinational round-robin search over a request vector
//
// Purpose: grants the first requesting channel found searching upward from
//          ptr, wrapping modulo NUM_CH.
// Ports:
//   req        in   NUM_CH  eligible requests
//   ptr        in   CH_W    channel the search starts from (always < NUM_CH)
//   gnt        out  NUM_CH  one-hot grant (all zero when nothing requests)
//   gnt_idx    out  CH_W    index of the granted channel
//   gnt_valid  out  1       a grant was made
module soc_rr_arb #(
    parameter  int NUM_CH = 2,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_valid
);

    always_comb begin : search
        int idx;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!gnt_valid && req[idx]) begin
                gnt[idx]  = 1'b1;
                gnt_idx   = CH_W'(idx);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/soc_mem_mc.sv
// rtl/soc_mem_mc.sv - multi-channel word memory with round-robin arbitration
//
// Purpose: NUM_CH requesters share one 2**INDEX_WIDTH x WORD_WIDTH array.
//          One transaction is granted per cycle; its ack follows one cycle
//          later. Optional even-parity storage is enabled by defining
//          SOC_MEM_PARITY_EN; otherwise err_o is tied to 0.
// Ports:
//   clk_i       in   1                   clock, rising edge
//   rst_i       in   1                   synchronous active-high reset
//   wr_i        in   NUM_CH              write request per channel (level)
//   ack_wr_o    out  NUM_CH              one-cycle write acknowledge
//   wr_data_i   in   NUM_CH*WORD_WIDTH   write data, channel c at [c*WORD_WIDTH +: WORD_WIDTH]
//   wr_index_i  in   NUM_CH*INDEX_WIDTH  write address, packed the same way
//   rd_i        in   NUM_CH              read request per channel (level)
//   ack_rd_o    out  NUM_CH              one-cycle read acknowledge
//   rd_data_o   out  NUM_CH*WORD_WIDTH   read data, valid in the ack cycle, then held
//   rd_index_i  in   NUM_CH*INDEX_WIDTH  read address, packed
//   err_o       out  NUM_CH              parity error, qualified by ack_rd_o
module soc_mem_mc
    import soc_mem_mc_pkg::*;
#(
    parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int NUM_CH      = DEF_NUM_CH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CH-1:0]             wr_i,
    output logic [NUM_CH-1:0]             ack_wr_o,
    input  logic [NUM_CH*WORD_WIDTH-1:0]  wr_data_i,
    input  logic [NUM_CH*INDEX_WIDTH-1:0] wr_index_i,
    input  logic [NUM_CH-1:0]             rd_i,
    output logic [NUM_CH-1:0]             ack_rd_o,
    output logic [NUM_CH*WORD_WIDTH-1:0]  rd_data_o,
    input  logic [NUM_CH*INDEX_WIDTH-1:0] rd_index_i,
    output logic [NUM_CH-1:0]             err_o
);

    localparam int DEPTH = 2 ** INDEX_WIDTH;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0]             rr_q;
    logic [NUM_CH-1:0]           ack_wr_q;
    logic [NUM_CH-1:0]           ack_rd_q;
    logic [NUM_CH*WORD_WIDTH-1:0] rd_data_q;
    logic [WORD_WIDTH-1:0]       mem_q [DEPTH];

    logic [NUM_CH-1:0]           elig;
    logic [NUM_CH-1:0]           gnt;
    logic [CH_W-1:0]             gnt_idx;
    logic                        gnt_valid;
    mem_op_e                     op;
    logic [INDEX_WIDTH-1:0]      sel_wr_idx;
    logic [INDEX_WIDTH-1:0]      sel_rd_idx;
    logic [WORD_WIDTH-1:0]       sel_wr_data;
    logic [WORD_WIDTH-1:0]       rd_word;

    // A channel whose ack is showing this cycle is still holding the request
    // it was just served for; masking it avoids serving that request twice.
    assign elig = (wr_i | rd_i) & ~(ack_wr_q | ack_rd_q);

    soc_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .req       (elig),
        .ptr       (rr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Write wins within a channel; its read stays pending for a later grant.
    always_comb begin
        sel_wr_idx  = wr_index_i[gnt_idx*INDEX_WIDTH +: INDEX_WIDTH];
        sel_rd_idx  = rd_index_i[gnt_idx*INDEX_WIDTH +: INDEX_WIDTH];
        sel_wr_data = wr_data_i[gnt_idx*WORD_WIDTH +: WORD_WIDTH];
        rd_word     = mem_q[sel_rd_idx];
        op          = wr_i[gnt_idx] ? OP_WR : OP_RD;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_wr_q  <= '0;
            ack_rd_q  <= '0;
            rd_data_q <= '0;
            rr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ack_wr_q <= gnt & {NUM_CH{op == OP_WR}};
            ack_rd_q <= gnt & {NUM_CH{op == OP_RD}};
            if (gnt_valid) begin
                rr_q <= CH_W'(rr_next(int'(gnt_idx), NUM_CH));
                if (op == OP_WR) begin
                    mem_q[sel_wr_idx] <= sel_wr_data;
                end else begin
                    rd_data_q[gnt_idx*WORD_WIDTH +: WORD_WIDTH] <= rd_word;
                end
            end
        end
    end

`ifdef SOC_MEM_PARITY_EN
    // Even parity: stored bit equals XOR of the data, so all-zero words
    // after reset are consistent.
    logic              par_q [DEPTH];
    logic [NUM_CH-1:0] err_q;
    logic              rd_perr;

    assign rd_perr = (^rd_word) != par_q[sel_rd_idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                par_q[i] <= 1'b0;
            end
        end else begin
            err_q <= gnt & {NUM_CH{(op == OP_RD) && rd_perr}};
            if (gnt_valid && (op == OP_WR)) begin
                par_q[sel_wr_idx] <= ^sel_wr_data;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = '0;
`endif

    assign ack_wr_o  = ack_wr_q;
    assign ack_rd_o  = ack_rd_q;
    assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_soc_mem_mc.sv
// tb/tb_soc_mem_mc.sv - scoreboard testbench for soc_mem_mc
module tb_soc_mem_mc;

    localparam int WW = 4;
    localparam int IW = 4;
    localparam int NC = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NC-1:0]    wr_i;
    logic [NC-1:0]    ack_wr_o;
    logic [NC*WW-1:0] wr_data_i;
    logic [NC*IW-1:0] wr_index_i;
    logic [NC-1:0]    rd_i;
    logic [NC-1:0]    ack_rd_o;
    logic [NC*WW-1:0] rd_data_o;
    logic [NC*IW-1:0] rd_index_i;
    logic [NC-1:0]    err_o;

    typedef struct {
        int          ch;
        bit          wr;
        logic [WW-1:0] data;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    soc_mem_mc #(.WORD_WIDTH(WW), .INDEX_WIDTH(IW), .NUM_CH(NC)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_i       (wr_i),
        .ack_wr_o   (ack_wr_o),
        .wr_data_i  (wr_data_i),
        .wr_index_i (wr_index_i),
        .rd_i       (rd_i),
        .ack_rd_o   (ack_rd_o),
        .rd_data_o  (rd_data_o),
        .rd_index_i (rd_index_i),
        .err_o      (err_o)
    );

    task automatic push(input int ch, input bit wr, input int data, input bit err, input int cyc);
        exp_t e;
        e.ch   = ch;
        e.wr   = wr;
        e.data = WW'(data);
        e.err  = err;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    task automatic drive_wr(input int ch, input int idx, input int data);
        wr_i[ch]               = 1'b1;
        wr_index_i[ch*IW +: IW] = IW'(idx);
        wr_data_i[ch*WW +: WW]  = WW'(data);
    endtask

    task automatic drive_rd(input int ch, input int idx);
        rd_i[ch]               = 1'b1;
        rd_index_i[ch*IW +: IW] = IW'(idx);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        wr_i = '0;
        rd_i = '0;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        int cyc;
        logic [WW-1:0] got;
        rst = 1'b1; wr_i = '0; rd_i = '0;
        wr_data_i = '0; wr_index_i = '0; rd_index_i = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (ack_wr_o !== 2'b00 || ack_rd_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_acks: ack_wr=%b ack_rd=%b, required 00 00", ack_wr_o, ack_rd_o);
        end
        checks++;
        if (rd_data_o !== '0) begin
            errors++;
            $display("FAIL reset_rd_data: got %h, required 00", rd_data_o);
        end
        checks++;
        if (err_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_err: got %b, required 00", err_o);
        end
        rst = 1'b0;
        drive_rd(0, 3);
        push(0, 0, 0, 0, 1);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 12) begin
            @(negedge clk);
            cyc++;
            for (int c = 0; c < NC; c++) begin
                if (ack_wr_o[c] || ack_rd_o[c]) begin
                    checks++;
                    got = rd_data_o[c*WW +: WW];
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL reset_read: unexpected ack on ch=%0d, required none", c);
                    end else begin
                        e = exp_q.pop_front();
                        if (c != e.ch || ack_wr_o[c] !== e.wr || cyc != e.cyc || err_o[c] !== e.err || (!e.wr && got !== e.data)) begin
                            errors++;
                            $display("FAIL reset_read: got ch=%0d wr=%0b cyc=%0d data=%h err=%0b, required ch=%0d wr=%0b cyc=%0d data=%h err=%0b",
                                     c, ack_wr_o[c], cyc, got, err_o[c], e.ch, e.wr, e.cyc, e.data, e.err);
                        end
                    end
                    if (ack_wr_o[c]) wr_i[c] = 1'b0; else rd_i[c] = 1'b0;
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_read timeout: %0d acks missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        int cyc;
        logic [WW-1:0] got;
        // {is_write, index, data, expected read data}
        int tbl [3][4] = '{'{0, 2, 0, 0}, '{1, 1, 5, 5}, '{0, 1, 0, 5}};
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (tbl[t][0] == 1) drive_wr(0, tbl[t][1], tbl[t][2]);
            else drive_rd(0, tbl[t][1]);
            push(0, tbl[t][0] == 1, tbl[t][3], 0, 1);
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 12) begin
                @(negedge clk);
                cyc++;
                for (int c = 0; c < NC; c++) begin
                    if (ack_wr_o[c] || ack_rd_o[c]) begin
                        checks++;
                        got = rd_data_o[c*WW +: WW];
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL write_read: unexpected ack on ch=%0d, required none", c);
                        end else begin
                            e = exp_q.pop_front();
                            if (c != e.ch || ack_wr_o[c] !== e.wr || cyc != e.cyc || err_o[c] !== e.err || (!e.wr && got !== e.data)) begin
                                errors++;
                                $display("FAIL write_read: got ch=%0d wr=%0b cyc=%0d data=%h err=%0b, required ch=%0d wr=%0b cyc=%0d data=%h err=%0b",
                                         c, ack_wr_o[c], cyc, got, err_o[c], e.ch, e.wr, e.cyc, e.data, e.err);
                            end
                        end
                        if (ack_wr_o[c]) wr_i[c] = 1'b0; else rd_i[c] = 1'b0;
                    end
                end
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL write_read timeout: %0d acks missing, required 0", exp_q.size());
                exp_q.delete();
            end
        end
        @(negedge clk);
        checks++;
        if (ack_wr_o !== 2'b00 || ack_rd_o !== 2'b00) begin
            errors++;
            $display("FAIL ack_pulse_width: ack_wr=%b ack_rd=%b, required 00 00", ack_wr_o, ack_rd_o);
        end
        checks++;
        if (rd_data_o[0 +: WW] !== 4'h5) begin
            errors++;
            $display("FAIL rd_data_hold: got %h, required 5", rd_data_o[0 +: WW]);
        end
    endtask

    task automatic test_contention();
        exp_t e;
        int cyc;
        logic [WW-1:0] got;
        do_reset();
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 0) begin
                drive_wr(0, 1, 7);
                drive_wr(1, 1, 9);
                push(0, 1, 7, 0, 1);
                push(1, 1, 9, 0, 2);
            end else begin
                @(negedge clk);
                drive_rd(0, 1);
                push(0, 0, 9, 0, 1);
            end
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 12) begin
                @(negedge clk);
                cyc++;
                for (int c = 0; c < NC; c++) begin
                    if (ack_wr_o[c] || ack_rd_o[c]) begin
                        checks++;
                        got = rd_data_o[c*WW +: WW];
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL contention: unexpected ack on ch=%0d, required none", c);
                        end else begin
                            e = exp_q.pop_front();
                            if (c != e.ch || ack_wr_o[c] !== e.wr || cyc != e.cyc || err_o[c] !== e.err || (!e.wr && got !== e.data)) begin
                                errors++;
                                $display("FAIL contention: got ch=%0d wr=%0b cyc=%0d data=%h err=%0b, required ch=%0d wr=%0b cyc=%0d data=%h err=%0b",
                                         c, ack_wr_o[c], cyc, got, err_o[c], e.ch, e.wr, e.cyc, e.data, e.err);
                            end
                        end
                        if (ack_wr_o[c]) wr_i[c] = 1'b0; else rd_i[c] = 1'b0;
                    end
                end
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL contention timeout: %0d acks missing, required 0", exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    task automatic test_fairness();
        exp_t e;
        int cyc;
        logic [WW-1:0] got;
        do_reset();
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 0) begin
                drive_wr(0, 5, 3);
                drive_wr(1, 6, 12);
                push(0, 1, 3, 0, 1);
                push(1, 1, 12, 0, 2);
            end else begin
                @(negedge clk);
                drive_rd(0, 5);
                drive_rd(1, 6);
                for (int i = 0; i < 8; i++) push(i % 2, 0, (i % 2) ? 12 : 3, 0, i + 1);
            end
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 16) begin
                @(negedge clk);
                cyc++;
                for (int c = 0; c < NC; c++) begin
                    if (ack_wr_o[c] || ack_rd_o[c]) begin
                        checks++;
                        got = rd_data_o[c*WW +: WW];
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL fairness: unexpected ack on ch=%0d, required none", c);
                        end else begin
                            e = exp_q.pop_front();
                            if (c != e.ch || ack_wr_o[c] !== e.wr || cyc != e.cyc || err_o[c] !== e.err || (!e.wr && got !== e.data)) begin
                                errors++;
                                $display("FAIL fairness: got ch=%0d wr=%0b cyc=%0d data=%h err=%0b, required ch=%0d wr=%0b cyc=%0d data=%h err=%0b",
                                         c, ack_wr_o[c], cyc, got, err_o[c], e.ch, e.wr, e.cyc, e.data, e.err);
                            end
                        end
                        // Writes are one-shot; reads stay requested for the whole burst.
                        if (ph == 0) wr_i[c] = 1'b0;
                    end
                end
            end
            rd_i = '0;
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL fairness timeout: %0d acks missing, required 0", exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    task automatic test_same_channel();
        exp_t e;
        int cyc;
        logic [WW-1:0] got;
        @(negedge clk);
        drive_wr(1, 4, 10);
        drive_rd(1, 4);
        push(1, 1, 10, 0, 1);
        push(1, 0, 10, 0, 3);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 12) begin
            @(negedge clk);
            cyc++;
            for (int c = 0; c < NC; c++) begin
                if (ack_wr_o[c] || ack_rd_o[c]) begin
                    checks++;
                    got = rd_data_o[c*WW +: WW];
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL same_channel: unexpected ack on ch=%0d, required none", c);
                    end else begin
                        e = exp_q.pop_front();
                        if (c != e.ch || ack_wr_o[c] !== e.wr || cyc != e.cyc || err_o[c] !== e.err || (!e.wr && got !== e.data)) begin
                            errors++;
                            $display("FAIL same_channel: got ch=%0d wr=%0b cyc=%0d data=%h err=%0b, required ch=%0d wr=%0b cyc=%0d data=%h err=%0b",
                                     c, ack_wr_o[c], cyc, got, err_o[c], e.ch, e.wr, e.cyc, e.data, e.err);
                        end
                    end
                    if (ack_wr_o[c]) wr_i[c] = 1'b0; else rd_i[c] = 1'b0;
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL same_channel timeout: %0d acks missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int cyc;
        logic [WW-1:0] got;
        @(negedge clk);
        // ch0 write is granted in the same cycle reset is sampled; ch1 read
        // is held across reset and must be served right after it.
        drive_wr(0, 4, 5);
        drive_rd(1, 4);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ack_wr_o !== 2'b00 || ack_rd_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_ack: ack_wr=%b ack_rd=%b, required 00 00", ack_wr_o, ack_rd_o);
        end
        wr_i[0] = 1'b0;
        rst = 1'b0;
        push(1, 0, 0, 0, 1);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 12) begin
            @(negedge clk);
            cyc++;
            for (int c = 0; c < NC; c++) begin
                if (ack_wr_o[c] || ack_rd_o[c]) begin
                    checks++;
                    got = rd_data_o[c*WW +: WW];
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL reset_mid: unexpected ack on ch=%0d, required none", c);
                    end else begin
                        e = exp_q.pop_front();
                        if (c != e.ch || ack_wr_o[c] !== e.wr || cyc != e.cyc || err_o[c] !== e.err || (!e.wr && got !== e.data)) begin
                            errors++;
                            $display("FAIL reset_mid: got ch=%0d wr=%0b cyc=%0d data=%h err=%0b, required ch=%0d wr=%0b cyc=%0d data=%h err=%0b",
                                     c, ack_wr_o[c], cyc, got, err_o[c], e.ch, e.wr, e.cyc, e.data, e.err);
                        end
                    end
                    if (ack_wr_o[c]) wr_i[c] = 1'b0; else rd_i[c] = 1'b0;
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid timeout: %0d acks missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

`ifdef SOC_MEM_PARITY_EN
    task automatic test_parity();
        exp_t e;
        int cyc;
        logic [WW-1:0] got;
        for (int ph = 0; ph < 2; ph++) begin
            @(negedge clk);
            if (ph == 0) begin
                drive_wr(0, 1, 5);
                push(0, 1, 5, 0, 1);
            end else begin
                dut.par_q[1] = ~dut.par_q[1];
                drive_rd(0, 1);
                push(0, 0, 5, 1, 1);
            end
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 12) begin
                @(negedge clk);
                cyc++;
                for (int c = 0; c < NC; c++) begin
                    if (ack_wr_o[c] || ack_rd_o[c]) begin
                        checks++;
                        got = rd_data_o[c*WW +: WW];
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL parity: unexpected ack on ch=%0d, required none", c);
                        end else begin
                            e = exp_q.pop_front();
                            if (c != e.ch || ack_wr_o[c] !== e.wr || cyc != e.cyc || err_o[c] !== e.err || (!e.wr && got !== e.data)) begin
                                errors++;
                                $display("FAIL parity: got ch=%0d wr=%0b cyc=%0d data=%h err=%0b, required ch=%0d wr=%0b cyc=%0d data=%h err=%0b",
                                         c, ack_wr_o[c], cyc, got, err_o[c], e.ch, e.wr, e.cyc, e.data, e.err);
                            end
                        end
                        if (ack_wr_o[c]) wr_i[c] = 1'b0; else rd_i[c] = 1'b0;
                    end
                end
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL parity timeout: %0d acks missing, required 0", exp_q.size());
                exp_q.delete();
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_fairness();
        test_same_channel();
        test_reset_mid();
`ifdef SOC_MEM_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
